// File: rtl/alu_host_sequencer.sv
// ============================================================================
// alu_host_sequencer: request/response front end sequencing a multi-cycle ALU.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_host_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_input,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  input  logic [WIDTH-1:0] req_z,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic             resp_err,
  output logic             alu_reset,
  output logic             BEGIN,
  output logic [1:0]       op_code,
  output logic [WIDTH-1:0] inbus,
  input  logic             load_a,
  input  logic             load_q,
  input  logic             load_m,
  input  logic             push_a,
  input  logic             push_q,
  input  logic [WIDTH-1:0] outbus,
  input  logic             END
);

  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0]      OP_MUL   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_RECOVER = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_a_q, pend_a_d, pend_q_q, pend_q_d;

  logic active, multi_load, legal, strobe_bad;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    pend_a_d = 1'b0;
    pend_q_d = 1'b0;
    BEGIN    = 1'b0;
    inbus    = '0;

    active     = (state_q == S_START) || (state_q == S_RUN);
    multi_load = (load_a & load_q) | (load_a & load_m) | (load_q & load_m);
    case (op_q)
      2'b00, 2'b01: legal = !(load_q || push_q);
      2'b10:        legal = !load_a;
      default:      legal = 1'b1;
    endcase
    strobe_bad = !legal || multi_load;

    // A bad strobe cycle poisons the transaction but does not stop it.
    if (active) begin
      if (strobe_bad) begin
        err_d = 1'b1;
      end else begin
        pend_a_d = push_a;
        pend_q_d = push_q;
        if (load_a)      inbus = x_q;
        else if (load_q) inbus = (op_q == OP_MUL) ? x_q : z_q;
        else if (load_m) inbus = y_q;
      end
    end

    // OUTBUS lags the push strobe by one cycle.
    if ((state_q == S_RUN) || (state_q == S_RECOVER)) begin
      if (pend_a_q) begin
        if (op_q[1]) hi_d = outbus;
        else         lo_d = outbus;
      end
      if (pend_q_q) lo_d = outbus;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          x_d     = req_x;
          y_d     = req_y;
          z_d     = req_z;
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        BEGIN   = 1'b1;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (END)                    state_d = S_RESP;
        else if (cnt_q == CNT_LAST) state_d = S_RECOVER;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      S_RECOVER: begin
        err_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_input) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      pend_a_q <= 1'b0;
      pend_q_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      pend_a_q <= pend_a_d;
      pend_q_q <= pend_q_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;
  assign resp_err   = err_q;
  assign op_code    = (state_q == S_IDLE) ? 2'b00 : op_q;
  assign alu_reset  = reset_input || (state_q == S_RECOVER);

endmodule

`default_nettype wire

// File: tb/tb_alu_host_sequencer.sv
// ============================================================================
// tb_alu_host_sequencer: directed and random transactions against a reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_host_sequencer;

  localparam int W  = 8;
  localparam int TO = 255;
  localparam logic [4:0] LA = 5'b10000, LQ = 5'b01000, LM = 5'b00100,
                         PA = 5'b00010, PQ = 5'b00001, NONE = 5'b00000;

  logic         clk = 1'b0;
  logic         reset_input, req_valid, resp_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_x, req_y, req_z, outbus;
  logic         load_a, load_q, load_m, push_a, push_q, alu_end;
  logic         req_ready, resp_valid, resp_err, alu_reset, alu_begin;
  logic [W-1:0] resp_hi, resp_lo, inbus;
  logic [1:0]   op_code;

  int checks = 0;
  int errors = 0;

  logic [1:0]   cur_op;
  logic [W-1:0] cur_x, cur_y, cur_z;
  logic         exp_err;

  alu_host_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_input(reset_input),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .resp_err(resp_err),
    .alu_reset(alu_reset), .BEGIN(alu_begin), .op_code(op_code), .inbus(inbus),
    .load_a(load_a), .load_q(load_q), .load_m(load_m),
    .push_a(push_a), .push_q(push_q), .outbus(outbus), .END(alu_end)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe legality straight from the operation table.
  function automatic logic bad_strobe(input logic [1:0] op, input logic [4:0] s);
    int   loads;
    logic ok;
    loads = int'(s[4]) + int'(s[3]) + int'(s[2]);
    case (op)
      2'd0, 2'd1: ok = !(s[3] || s[0]);
      2'd2:       ok = !s[4];
      default:    ok = 1'b1;
    endcase
    return !ok || (loads > 1);
  endfunction

  function automatic logic [W-1:0] ref_inbus(input logic [4:0] s);
    if (bad_strobe(cur_op, s)) return '0;
    if (s[4]) return cur_x;
    if (s[3]) return (cur_op == 2'd2) ? cur_x : cur_z;
    if (s[2]) return cur_y;
    return '0;
  endfunction

  // {hi, lo} the arithmetic says the ALU should deliver.
  function automatic logic [2*W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] x,
                                                input logic [W-1:0] y, input logic [W-1:0] z);
    logic [W-1:0]   s;
    logic [2*W-1:0] dvd, q, r;
    case (op)
      2'd0: begin s = x + y; return {{W{1'b0}}, s}; end
      2'd1: begin s = x - y; return {{W{1'b0}}, s}; end
      2'd2: return {{W{1'b0}}, x} * {{W{1'b0}}, y};
      default: begin
        dvd = {x, z};
        q   = dvd / {{W{1'b0}}, y};
        r   = dvd % {{W{1'b0}}, y};
        return {r[W-1:0], q[W-1:0]};
      end
    endcase
  endfunction

  task automatic drive_strobes(input logic [4:0] s, input logic [W-1:0] ob, input logic e);
    {load_a, load_q, load_m, push_a, push_q} = s;
    outbus  = ob;
    alu_end = e;
  endtask

  // One RUN cycle of the ALU model, entered and left at a falling edge.
  task automatic step(input logic [4:0] s, input logic [W-1:0] ob, input logic e);
    drive_strobes(s, ob, e);
    #1;
    chk("inbus", inbus, ref_inbus(s));
    chk("begin_run", alu_begin, 1'b0);
    chk("op_code_run", op_code, cur_op);
    if (bad_strobe(cur_op, s)) exp_err = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_txn(input logic [1:0] op, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] z);
    cur_op = op; cur_x = x; cur_y = y; cur_z = z; exp_err = 1'b0;
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_z = z;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_x = W'($urandom); req_y = W'($urandom); req_z = W'($urandom);
    chk("begin_start", alu_begin, 1'b1);
    chk("op_code_start", op_code, op);
    chk("req_ready_busy", req_ready, 1'b0);
    @(negedge clk);
  endtask

  task automatic check_resp(input logic [W-1:0] hi, input logic [W-1:0] lo,
                            input logic err, input int stall);
    drive_strobes(NONE, '0, 1'b0);
    #1;
    chk("resp_valid", resp_valid, 1'b1);
    chk("req_ready_resp", req_ready, 1'b0);
    chk("resp_hi", resp_hi, hi);
    chk("resp_lo", resp_lo, lo);
    chk("resp_err", resp_err, err);
    chk("op_code_resp", op_code, cur_op);
    chk("inbus_resp", inbus, '0);
    for (int i = 0; i < stall; i++) begin
      resp_ready = 1'b0;
      drive_strobes(LA | PA | PQ, W'($urandom), 1'b1);
      @(negedge clk);
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_hi", resp_hi, hi);
      chk("stall_lo", resp_lo, lo);
      chk("stall_err", resp_err, err);
    end
    drive_strobes(NONE, '0, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_valid", resp_valid, 1'b0);
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_op_code", op_code, 2'b00);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z, input logic [4:0] pre, input int stall);
    logic [2*W-1:0] r;
    r = ref_result(op, x, y, z);
    start_txn(op, x, y, z);
    if (pre != NONE) step(pre, '0, 1'b0);
    case (op)
      2'd0, 2'd1: begin
        step(LA, '0, 1'b0); step(LM, '0, 1'b0);
        step(PA, ~r[W-1:0], 1'b0); step(NONE, r[W-1:0], 1'b1);
      end
      2'd2: begin
        step(LQ, '0, 1'b0); step(LM, '0, 1'b0);
        step(PA, ~r[2*W-1:W], 1'b0); step(PQ, r[2*W-1:W], 1'b0);
        step(NONE, r[W-1:0], 1'b1);
      end
      default: begin
        step(LA, '0, 1'b0); step(LQ, '0, 1'b0); step(LM, '0, 1'b0);
        step(PQ, ~r[W-1:0], 1'b0); step(PA, r[W-1:0], 1'b0);
        step(NONE, r[2*W-1:W], 1'b1);
      end
    endcase
    check_resp(r[2*W-1:W], r[W-1:0], exp_err, stall);
  endtask

  initial begin
    int runc;
    logic [1:0]   op;
    logic [W-1:0] x, y, z;

    reset_input = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_x = '0; req_y = '0; req_z = '0;
    cur_op = '0; cur_x = '0; cur_y = '0; cur_z = '0; exp_err = 1'b0;
    drive_strobes(NONE, '0, 1'b0);
    repeat (2) @(negedge clk);
    chk("alu_reset_in_reset", alu_reset, 1'b1);
    reset_input = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_hi", resp_hi, '0);
    chk("rst_resp_lo", resp_lo, '0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_begin", alu_begin, 1'b0);
    chk("rst_op_code", op_code, 2'b00);
    chk("rst_alu_reset", alu_reset, 1'b0);

    run_txn(2'd0, 8'h12, 8'h34, 8'h00, NONE, 0);
    run_txn(2'd2, 8'h07, 8'h09, 8'h00, NONE, 1);
    run_txn(2'd3, 8'h00, 8'h07, 8'h64, NONE, 2);
    run_txn(2'd1, 8'h10, 8'h20, 8'h00, NONE, 5);
    run_txn(2'd0, 8'hFF, 8'h01, 8'h00, LQ, 0);
    run_txn(2'd3, 8'h01, 8'h05, 8'h22, LA | LM, 1);
    run_txn(2'd2, 8'h03, 8'h04, 8'h00, LA, 0);

    // Timeout: partial result kept, error flagged, single alu_reset pulse.
    start_txn(2'd0, 8'h11, 8'h22, 8'h00);
    step(LA, '0, 1'b0);
    step(PA, 8'h00, 1'b0);
    step(NONE, 8'hA5, 1'b0);
    drive_strobes(NONE, '0, 1'b0);
    runc = 3;
    while (alu_reset !== 1'b1 && runc < 1000) begin
      runc++;
      @(negedge clk);
    end
    chk("timeout_run_cycles", runc, TO);
    chk("timeout_recover_valid", resp_valid, 1'b0);
    @(negedge clk);
    chk("timeout_alu_reset_pulse", alu_reset, 1'b0);
    check_resp(8'h00, 8'hA5, 1'b1, 1);

    // END on the final allowed RUN cycle beats the timeout.
    start_txn(2'd1, 8'h05, 8'h01, 8'h00);
    drive_strobes(NONE, '0, 1'b0);
    repeat (TO - 1) begin
      chk("late_end_no_reset", alu_reset, 1'b0);
      @(negedge clk);
    end
    alu_end = 1'b1;
    @(negedge clk);
    chk("late_end_alu_reset", alu_reset, 1'b0);
    check_resp(8'h00, 8'h00, 1'b0, 0);

    // Reset while RUN, with a captured partial result to be wiped.
    start_txn(2'd0, 8'h12, 8'h34, 8'h00);
    step(LA, '0, 1'b0);
    step(PA, 8'h00, 1'b0);
    step(NONE, 8'h55, 1'b0);
    chk("mid_partial_lo", resp_lo, 8'h55);
    reset_input = 1'b1;
    #1;
    chk("mid_alu_reset", alu_reset, 1'b1);
    @(negedge clk);
    reset_input = 1'b0;
    #1;
    chk("mid_req_ready", req_ready, 1'b1);
    chk("mid_resp_valid", resp_valid, 1'b0);
    chk("mid_resp_lo", resp_lo, '0);
    chk("mid_resp_err", resp_err, 1'b0);
    chk("mid_op_code", op_code, 2'b00);
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom);
      x  = W'($urandom);
      z  = W'($urandom);
      y  = W'($urandom_range(1, (1 << W) - 1));
      if (op == 2'd3) x = W'($urandom % y);
      run_txn(op, x, y, z, NONE, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_host_sequencer.md
ALU_HOST_SEQUENCER -- requirements
Module: alu_host_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Parameter: TIMEOUT, 255, max RUN cycles before abort.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset_input  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  client request present.
REQ-006 req_ready  output  1  sequencer accepts request this cycle.
REQ-007 req_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 req_x  input  WIDTH  add/sub: A operand; mul: multiplier (Q); div: dividend high (A).
REQ-009 req_y  input  WIDTH  second operand / multiplicand / divisor (M).
REQ-010 req_z  input  WIDTH  div only: dividend low (Q); ignored otherwise.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  client consumes result.
REQ-013 resp_hi  output  WIDTH  A result: 0 for add/sub, product high for mul, remainder for div.
REQ-014 resp_lo  output  WIDTH  add/sub result, product low (Q), or quotient (Q).
REQ-015 resp_err  output  1  timeout or protocol violation in this transaction.
REQ-016 alu_reset  output  1  drives ALU control-unit reset, active-high.
REQ-017 BEGIN  output  1  start pulse to ALU.
REQ-018 op_code  output  2  operation to ALU.
REQ-019 inbus  output  WIDTH  operand bus to ALU.
REQ-020 load_a, load_q, load_m  input  1 each  ALU register-load strobes.
REQ-021 push_a, push_q  input  1 each  ALU OUTBUS-push strobes.
REQ-022 outbus  input  WIDTH  ALU result bus.
REQ-023 END  input  1  ALU completion pulse.

Function
REQ-024 States SHALL be IDLE, START, RUN, RECOVER, RESP.
REQ-025 IDLE: req_ready=1; req_valid=1 latches op/x/y/z, clears resp_hi/lo/err, -> START.
REQ-026 START: BEGIN=1 for exactly this one cycle, -> RUN; BEGIN SHALL be 0 in all other states.
REQ-027 op_code SHALL equal latched op from START through RESP; 00 in IDLE.
REQ-028 inbus, combinational in START and RUN: load_a -> A operand, load_q -> Q operand, load_m -> req_y latch; no strobe -> 0; 0 outside START/RUN.
REQ-029 Legal strobes: add/sub load_a, load_m, push_a; mul load_q, load_m, push_a, push_q; div all five. Illegal strobe or >1 load strobe in a cycle SHALL set resp_err sticky and drive inbus 0; transaction continues.
REQ-030 Push strobe high in cycle N: outbus SHALL be captured at the edge ending cycle N+1 (push_a -> resp_hi, push_q -> resp_lo; add/sub push_a -> resp_lo, resp_hi stays 0).
REQ-031 RUN: END=1 -> RESP (pending capture completes on same edge).
REQ-032 RUN cycle counter SHALL clear on START; counter reaching TIMEOUT without END -> RECOVER.
REQ-033 RECOVER: alu_reset=1 for one cycle, resp_err=1, -> RESP; captured partial results retained.
REQ-034 RESP: resp_valid=1, outputs stable until resp_ready=1 -> IDLE; END or strobes here ignored.
REQ-035 END in IDLE or START SHALL be ignored; END and timeout in same cycle: END wins, no error.
REQ-036 No new request accepted until RESP completes (one transaction in flight).

Reset
REQ-037 reset_input=1 at any edge: state IDLE, req_ready=1 next cycle, resp_valid=0, resp_hi/lo=0, resp_err=0, BEGIN=0, op_code=00, counter=0.
REQ-038 alu_reset SHALL equal reset_input OR (state==RECOVER), so ALU resets with the sequencer mid-operation.

Verification
REQ-039 Add: x=0x12,y=0x34; model ALU load_a, load_m, push_a -> inbus 0x12 then 0x34, resp_lo=0x46, resp_hi=0, err=0.
REQ-040 Mul: x=0x07,y=0x09; strobes load_q, load_m, push_a, push_q -> inbus 0x07,0x09; resp={0x00,0x3F}.
REQ-041 Div: x=0x00,z=0x64,y=0x07 -> inbus order 0x00,0x64,0x07; push_q then push_a -> resp_lo=0x0E, resp_hi=0x02.
REQ-042 Timeout: ALU never asserts END -> after TIMEOUT RUN cycles alu_reset pulses 1 cycle, resp_valid=1, resp_err=1.
REQ-043 Protocol error: add with load_q strobe -> inbus 0 that cycle, resp_err=1 at RESP.
REQ-044 Reset mid-RUN and resp_ready held 0 for 5 cycles in RESP -> IDLE next cycle; resp outputs held stable while stalled.
